hub75_bcm_scan: RTL and testbench

- Scan controller for the HUB75 output path. Replaces the free-running pixel sequencer and the per-frame 5-bit PWM comparator with binary-coded-modulation (BCM) scheduling.
- For each row and each bit plane it:
  - walks the pixel index into the pixel mapper / pixel RAM,
  - shifts one bit plane of RGB555 data into the panel,
  - latches it,
  - holds OE for a time weighted by the plane's significance.
- Sits between the pixel RAM read port (via the mapper) and the panel pins. Same clock as the SPI/RAM side.

---
 rtl/hub75_pkg.sv | 28 ++
 rtl/hub75_oe_timer.sv | 41 ++++
 rtl/hub75_bcm_scan.sv | 164 ++++++++++++++++
 tb/tb_hub75_bcm_scan.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 BCM scan controller: FSM states,
// RGB555 field offsets and the per-plane OE hold time.
package hub75_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } hub75_state_e;

    localparam int R_LSB = 10;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;

    // Plane p is lit for BASE_ON << p cycles, giving binary weighting.
    function automatic int oe_cycles(input int base_on, input int plane);
        return base_on << plane;
    endfunction

    // Pick the {r,g,b} bits of one bit plane out of an RGB555 word.
    function automatic logic [2:0] rgb_bits(input logic [15:0] px, input int plane);
        logic [15:0] s;
        s = px >> plane;
        return {s[R_LSB], s[G_LSB], s[B_LSB]};
    endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// Loadable down-counter that holds the panel OE (active low) asserted while
// the count is nonzero; done means the lit interval is over.
module hub75_oe_timer #(
    parameter int TW = 7
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          hub_oe,
    output logic          done
);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          oe_q, oe_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
        oe_d = (cnt_d == '0);
    end

    // Reset drives OE high immediately so a panel never stays lit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            oe_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            oe_q  <= oe_d;
        end
    end

    assign hub_oe = oe_q;
    assign done   = (cnt_q == '0);

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 scan controller: per row and bit plane, shift one plane of RGB555
// data into the panel, latch it, then light it for a BCM-weighted time.
module hub75_bcm_scan
    import hub75_pkg::*;
#(
    parameter int COLS     = 32,
    parameter int ROW_BITS = 4,
    parameter int PLANES   = 5,
    parameter int BASE_ON  = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                enable,
    output logic [11:0]         pixel,
    input  logic [15:0]         rdata1,
    input  logic [15:0]         rdata2,
    output logic                hub_r1,
    output logic                hub_g1,
    output logic                hub_b1,
    output logic                hub_r2,
    output logic                hub_g2,
    output logic                hub_b2,
    output logic                hub_clk,
    output logic                hub_lat,
    output logic                hub_oe,
    output logic [ROW_BITS-1:0] hub_row,
    output logic                frame_done,
    output logic [1:0]          dbg_state
);

    localparam int CB  = $clog2(COLS);
    localparam int PB  = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int SCW = $clog2(2 * COLS + 1);
    localparam int TW  = $clog2(oe_cycles(BASE_ON, PLANES - 1) + 1);

    hub75_state_e        state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [PB-1:0]       plane_q, plane_d;
    logic [CB-1:0]       col_q, col_d;
    logic [SCW-1:0]      sc_q, sc_d;
    logic                lc_q, lc_d;
    logic [2:0]          rgb1_q, rgb1_d, rgb2_q, rgb2_d;
    logic                clk_q, clk_d, lat_q, lat_d, fd_q, fd_d;
    logic [ROW_BITS-1:0] hub_row_q, hub_row_d;
    logic                tmr_load, tmr_done;

    hub75_oe_timer #(.TW(TW)) u_oe_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (TW'(oe_cycles(BASE_ON, int'(plane_q)))),
        .hub_oe   (hub_oe),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        plane_d   = plane_q;
        col_d     = col_q;
        sc_d      = sc_q;
        lc_d      = lc_q;
        rgb1_d    = rgb1_q;
        rgb2_d    = rgb2_q;
        clk_d     = clk_q;
        lat_d     = 1'b0;
        fd_d      = 1'b0;
        hub_row_d = hub_row_q;
        tmr_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SHIFT;
                    sc_d    = '0;
                end
            end
            SHIFT: begin
                sc_d = sc_q + SCW'(1);
                // Odd cycles see rdata for the column presented one cycle earlier.
                if (sc_q[0]) begin
                    rgb1_d = rgb_bits(rdata1, int'(plane_q));
                    rgb2_d = rgb_bits(rdata2, int'(plane_q));
                    clk_d  = 1'b0;
                    if (col_q != CB'(COLS - 1)) begin
                        col_d = col_q + CB'(1);
                    end
                end else if (sc_q != '0) begin
                    clk_d = 1'b1;
                end
                if (sc_q == SCW'(2 * COLS)) begin
                    state_d = LATCH;
                    sc_d    = '0;
                    lc_d    = 1'b0;
                    col_d   = '0;
                end
            end
            LATCH: begin
                if (!lc_q) begin
                    lc_d      = 1'b1;
                    clk_d     = 1'b0;
                    hub_row_d = row_q;
                    lat_d     = 1'b1;
                end else begin
                    state_d  = DISPLAY;
                    tmr_load = 1'b1;
                end
            end
            DISPLAY: begin
                if (tmr_done) begin
                    if (plane_q == PB'(PLANES - 1)) begin
                        plane_d = '0;
                        row_d   = row_q + ROW_BITS'(1);
                        fd_d    = (row_q == '1);
                    end else begin
                        plane_d = plane_q + PB'(1);
                    end
                    sc_d    = '0;
                    state_d = enable ? SHIFT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            row_q     <= '0;
            plane_q   <= '0;
            col_q     <= '0;
            sc_q      <= '0;
            lc_q      <= 1'b0;
            rgb1_q    <= '0;
            rgb2_q    <= '0;
            clk_q     <= 1'b0;
            lat_q     <= 1'b0;
            fd_q      <= 1'b0;
            hub_row_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            col_q     <= col_d;
            sc_q      <= sc_d;
            lc_q      <= lc_d;
            rgb1_q    <= rgb1_d;
            rgb2_q    <= rgb2_d;
            clk_q     <= clk_d;
            lat_q     <= lat_d;
            fd_q      <= fd_d;
            hub_row_q <= hub_row_d;
        end
    end

    assign pixel      = 12'({row_q, col_q});
    assign {hub_r1, hub_g1, hub_b1} = rgb1_q;
    assign {hub_r2, hub_g2, hub_b2} = rgb2_q;
    assign hub_clk    = clk_q;
    assign hub_lat    = lat_q;
    assign hub_row    = hub_row_q;
    assign frame_done = fd_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Directed bench for hub75_bcm_scan: full frame of BCM timing, enable
// drop/resume at a plane boundary, and asynchronous reset during DISPLAY.
module tb_hub75_bcm_scan;

    logic        clock = 1'b0;
    logic        resetn;
    logic        enable;
    logic [11:0] pixel;
    logic [15:0] rdata1 = 16'h0000;
    logic [15:0] rdata2 = 16'h0000;
    logic        hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic        hub_clk, hub_lat, hub_oe, frame_done;
    logic [3:0]  hub_row;
    logic [1:0]  dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    hub75_bcm_scan #(.COLS(32), .ROW_BITS(4), .PLANES(5), .BASE_ON(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .enable     (enable),
        .pixel      (pixel),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .hub_r1     (hub_r1),
        .hub_g1     (hub_g1),
        .hub_b1     (hub_b1),
        .hub_r2     (hub_r2),
        .hub_g2     (hub_g2),
        .hub_b2     (hub_b2),
        .hub_clk    (hub_clk),
        .hub_lat    (hub_lat),
        .hub_oe     (hub_oe),
        .hub_row    (hub_row),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: registered read, data valid one cycle after pixel.
    // Upper half: full red. Lower half: blue 10101b, plus full green on column 31.
    always @(posedge clock) begin
        rdata1 <= 16'h7C00;
        rdata2 <= (pixel[4:0] == 5'd31) ? 16'h03F5 : 16'h0015;
    end

    // panel-side monitor, sampled on the falling edge
    logic [4:0] exp_b2 = 5'b10101;
    int   exp_oe[5] = '{4, 8, 16, 32, 64};
    int   edge_cnt = 0, lat_cnt = 0, oe_rise_cnt = 0, oe_low = 0;
    int   last_oe_len = 0, last_lat_row = 0, last_lat_edges = 0;
    int   fd_cnt = 0, fd_cyc = 0, fd_pixel = -1, max_pixel = 0;
    int   tb_row = 0, tb_plane = 0;
    int   bad_r1 = 0, bad_other = 0, bad_b2 = 0, bad_g2 = 0;
    int   bad_lat_edges = 0, bad_lat_row = 0, bad_lat_width = 0;
    int   bad_oe_len = 0, bad_row_move = 0;
    int   oe_len_row0[5] = '{0, 0, 0, 0, 0};
    logic prev_clk = 1'b0, prev_lat = 1'b0, prev_oe = 1'b1;
    logic [3:0] prev_row = 4'd0;

    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            if (hub_clk && !prev_clk) begin
                edge_cnt++;
                if (hub_r1 !== 1'b1) bad_r1++;
                if (hub_g1 || hub_b1 || hub_r2) bad_other++;
                if (hub_b2 !== exp_b2[tb_plane]) bad_b2++;
                if (hub_g2 !== (edge_cnt == 32)) bad_g2++;
            end
            if (hub_lat) begin
                if (prev_lat) bad_lat_width++;
                else begin
                    lat_cnt++;
                    last_lat_edges = edge_cnt;
                    last_lat_row   = int'(hub_row);
                    if (edge_cnt != 32) bad_lat_edges++;
                    if (int'(hub_row) != tb_row) bad_lat_row++;
                    edge_cnt = 0;
                end
            end
            if (!hub_oe) begin
                oe_low++;
                if (hub_row != prev_row) bad_row_move++;
            end
            if (hub_oe && !prev_oe) begin
                oe_rise_cnt++;
                last_oe_len = oe_low;
                if (oe_low != exp_oe[tb_plane]) bad_oe_len++;
                if (tb_row == 0) oe_len_row0[tb_plane] = oe_low;
                oe_low = 0;
                if (tb_plane == 4) begin
                    tb_plane = 0;
                    tb_row   = (tb_row + 1) % 16;
                end else begin
                    tb_plane++;
                end
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc   = cyc;
                fd_pixel = int'(pixel);
            end
            if (int'(pixel) > max_pixel) max_pixel = int'(pixel);
            prev_clk = hub_clk;
            prev_lat = hub_lat;
            prev_oe  = hub_oe;
            prev_row = hub_row;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int start_cyc, lat_at_stop, rise_at_stop;

    initial begin
        // reset hold
        resetn = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_oe", 32'(hub_oe), 1);
        chk("rst_clk", 32'(hub_clk), 0);
        chk("rst_lat", 32'(hub_lat), 0);
        chk("rst_pixel", 32'(pixel), 0);
        chk("rst_row", 32'(hub_row), 0);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_data", 32'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}), 0);
        chk("rst_state", 32'(dbg_state), 0);

        // released but disabled: stays idle
        resetn = 1'b1;
        repeat (50) @(negedge clock);
        chk("idle_oe", 32'(hub_oe), 1);
        chk("idle_clk", 32'(hub_clk), 0);
        chk("idle_lat_cnt", 32'(lat_cnt), 0);
        chk("idle_pixel", 32'(pixel), 0);
        chk("idle_fd_cnt", 32'(fd_cnt), 0);
        chk("idle_state", 32'(dbg_state), 0);

        // one full frame
        enable    = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < 10000 && fd_cnt == 0; i++) @(negedge clock);
        chk("frame_fd_cnt", 32'(fd_cnt), 1);
        chk("frame_fd_latency", 32'(fd_cyc - start_cyc), 7425);
        chk("frame_wrap_pixel", 32'(fd_pixel), 0);
        chk("frame_lat_cnt", 32'(lat_cnt), 80);
        chk("frame_oe_cnt", 32'(oe_rise_cnt), 80);
        for (int p = 0; p < 5; p++) chk("frame_oe_len_row0", 32'(oe_len_row0[p]), 32'(exp_oe[p]));
        chk("frame_row_wrap", 32'(tb_row), 0);
        chk("frame_max_pixel", 32'(max_pixel), 511);
        chk("bad_r1", 32'(bad_r1), 0);
        chk("bad_other_colours", 32'(bad_other), 0);
        chk("bad_b2_planes", 32'(bad_b2), 0);
        chk("bad_g2_last_col", 32'(bad_g2), 0);
        chk("bad_lat_edges", 32'(bad_lat_edges), 0);
        chk("bad_lat_row", 32'(bad_lat_row), 0);
        chk("bad_lat_width", 32'(bad_lat_width), 0);
        chk("bad_oe_len", 32'(bad_oe_len), 0);
        chk("bad_row_move", 32'(bad_row_move), 0);

        // drop enable mid-SHIFT of row 3, plane 2
        for (int i = 0; i < 10000 && !(tb_row == 3 && tb_plane == 2 && edge_cnt >= 5); i++)
            @(negedge clock);
        chk("stop_point_reached", 32'(tb_row == 3 && tb_plane == 2 && edge_cnt >= 5), 1);
        enable       = 1'b0;
        lat_at_stop  = lat_cnt;
        rise_at_stop = oe_rise_cnt;
        for (int i = 0; i < 1000 && oe_rise_cnt == rise_at_stop; i++) @(negedge clock);
        repeat (100) @(negedge clock);
        chk("stop_state_idle", 32'(dbg_state), 0);
        chk("stop_oe_high", 32'(hub_oe), 1);
        chk("stop_lat_cnt", 32'(lat_cnt - lat_at_stop), 1);
        chk("stop_oe_cnt", 32'(oe_rise_cnt - rise_at_stop), 1);
        chk("stop_oe_len", 32'(last_oe_len), 16);
        chk("stop_lat_row", 32'(last_lat_row), 3);
        chk("stop_pixel", 32'(pixel), 96);

        // resume at row 3, plane 3
        enable = 1'b1;
        for (int i = 0; i < 1000 && oe_rise_cnt == rise_at_stop + 1; i++) @(negedge clock);
        chk("resume_oe_cnt", 32'(oe_rise_cnt - rise_at_stop), 2);
        chk("resume_oe_len", 32'(last_oe_len), 32);
        chk("resume_lat_row", 32'(last_lat_row), 3);
        chk("resume_lat_edges", 32'(last_lat_edges), 32);

        // asynchronous reset while lit
        for (int i = 0; i < 1000 && hub_oe !== 1'b0; i++) @(negedge clock);
        chk("display_reached", 32'(hub_oe), 0);
        #2 resetn = 1'b0;
        #1;
        chk("async_oe", 32'(hub_oe), 1);
        chk("async_lat", 32'(hub_lat), 0);
        chk("async_clk", 32'(hub_clk), 0);
        @(negedge clock);
        chk("async_state", 32'(dbg_state), 0);
        chk("async_pixel", 32'(pixel), 0);
        chk("async_row", 32'(hub_row), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
